line_memory_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 21 ++
 rtl/line_ram.sv | 33 +++
 rtl/line_memory_responder.sv | 99 +++++++++
 tb/tb_line_memory_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM state encoding and address helpers for the line memory responder.
package mem_pkg;

   localparam int LINE_W      = 256;
   localparam int OFFSET_BITS = 5;
   localparam int MEM_LATENCY = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Drops the byte offset and wraps the line number into the array depth.
   function automatic int unsigned line_index(input logic [31:0] addr,
                                              input int unsigned offset_bits,
                                              input int unsigned lines);
      return (addr >> offset_bits) % lines;
   endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port synchronous line array; rdata is registered and only changes on an access.
module line_ram #(
   parameter int width = 256,
   parameter int depth = 2048,
   parameter int index_width = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   we,
   input  logic [index_width-1:0] index,
   input  logic [width-1:0]       wdata,
   output logic [width-1:0]       rdata
);

   // Contents survive reset; the declaration initialiser gives a clean array at time 0.
   logic [width-1:0] mem [depth] = '{default: '0};

   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[index] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= we ? wdata : mem[index];
      end
   end

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency backing store for cache line reads and writebacks, one request in flight.
module line_memory_responder
   import mem_pkg::*;
#(
   parameter int cache_line_width   = LINE_W,
   parameter int addr_width         = 16,
   parameter int num_bytes_per_line = 32,
   parameter int mem_lines          = 2048,
   parameter int mem_latency        = MEM_LATENCY
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   input  logic                        req_we,
   input  logic [addr_width-1:0]       req_addr,
   input  logic [cache_line_width-1:0] req_wdata,
   output logic                        req_ready,
   output logic                        resp_valid,
   output logic                        resp_we,
   output logic [cache_line_width-1:0] resp_rdata,
   output state_t                      state_dbg
);

   localparam int IW = (mem_lines > 1) ? $clog2(mem_lines) : 1;
   localparam int OB = $clog2(num_bytes_per_line);
   localparam int CW = (mem_latency > 1) ? $clog2(mem_latency) : 1;

   state_t                      state;
   logic [CW-1:0]               count;
   logic                        we_q;
   logic [IW-1:0]               idx_q;
   logic [cache_line_width-1:0] wdata_q;
   logic                        access;

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both
   // high; the initiator holds it stable until then. resp_valid is a one-cycle strobe with
   // no back-pressure, and req_ready only rises again in the cycle after that strobe.
   assign access    = (state == BUSY) && (count == '0) && !reset;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_we    <= 1'b0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid && req_ready) begin
                  we_q      <= req_we;
                  idx_q     <= IW'(line_index(32'(req_addr), OB, mem_lines));
                  wdata_q   <= req_wdata;
                  count     <= CW'(mem_latency - 1);
                  req_ready <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // The array access itself happens in line_ram on this same edge.
               if (count == '0) begin
                  resp_valid <= 1'b1;
                  resp_we    <= we_q;
                  state      <= RESP;
               end else begin
                  count <= count - 1'b1;
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

   line_ram #(
      .width       (cache_line_width),
      .depth       (mem_lines),
      .index_width (IW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .en    (access),
      .we    (we_q),
      .index (idx_q),
      .wdata (wdata_q),
      .rdata (resp_rdata)
   );

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: a full-size instance plus a 16-line instance sharing stimulus.
module tb_line_memory_responder;
   import mem_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_we;
   logic [15:0]  req_addr;
   logic [255:0] req_wdata;

   logic         req_ready,   req_ready_w;
   logic         resp_valid,  resp_valid_w;
   logic         resp_we,     resp_we_w;
   logic [255:0] resp_rdata,  resp_rdata_w;
   state_t       state_dbg,   state_dbg_w;

   int total = 0;
   int bad   = 0;

   logic [255:0] pat_a5;
   logic [255:0] pat_one;
   logic [255:0] pat_c3;

   always #5 clk = ~clk;

   line_memory_responder dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_we    (resp_we),
      .resp_rdata (resp_rdata),
      .state_dbg  (state_dbg)
   );

   line_memory_responder #(.mem_lines(16)) dut_w (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready_w),
      .resp_valid (resp_valid_w),
      .resp_we    (resp_we_w),
      .resp_rdata (resp_rdata_w),
      .state_dbg  (state_dbg_w)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
   task automatic run_req(input string tag, input logic we, input logic [15:0] addr,
                          input logic [255:0] wd, input logic [255:0] exp_rd,
                          input logic chk_w, input logic [255:0] exp_w);
      logic rdy_seen;
      logic rv_seen;
      rdy_seen  = 1'b0;
      rv_seen   = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         if (j > 1) @(negedge clk);
         rdy_seen |= req_ready;
         rv_seen  |= resp_valid;
      end
      check({tag, "_busy_ready_low"}, 256'(rdy_seen), 256'(0));
      check({tag, "_busy_no_resp"}, 256'(rv_seen), 256'(0));
      @(negedge clk);
      check({tag, "_resp_valid"}, 256'(resp_valid), 256'(1));
      check({tag, "_resp_we"}, 256'(resp_we), 256'(we));
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_resp_ready_low"}, 256'(req_ready), 256'(0));
      if (chk_w) check({tag, "_wrap_rdata"}, resp_rdata_w, exp_w);
      @(negedge clk);
      check({tag, "_after_resp_valid"}, 256'(resp_valid), 256'(0));
      check({tag, "_after_ready"}, 256'(req_ready), 256'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] rdy_hist;
      logic [63:0] rv_hist;
      logic [63:0] exp_rdy;
      logic [63:0] exp_rv;
      logic        rv_seen;

      pat_a5    = {32{8'hA5}};
      pat_one   = 256'h1;
      pat_c3    = {32{8'hC3}};
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset, then 20 idle cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_state", 256'(state_dbg), 256'(IDLE));
      check("reset_resp_we", 256'(resp_we), 256'(0));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_ready", 256'(req_ready), 256'(1));
         check("idle_resp_valid", 256'(resp_valid), 256'(0));
         check("idle_rdata", resp_rdata, 256'(0));
      end

      // Write, read back through a different offset, read an untouched line.
      run_req("wr_0040", 1'b1, 16'h0040, pat_a5, pat_a5, 1'b0, '0);
      run_req("rd_004f", 1'b0, 16'h004F, '0, pat_a5, 1'b0, '0);
      run_req("rd_0060", 1'b0, 16'h0060, '0, 256'(0), 1'b0, '0);
      run_req("rd_0040", 1'b0, 16'h0040, '0, pat_a5, 1'b0, '0);
      repeat (4) @(negedge clk);
      check("rdata_stable", resp_rdata, pat_a5);

      // Back-to-back reads with req_valid held: IDLE, 10 BUSY, RESP gives a 12-cycle period.
      rdy_hist  = '0;
      rv_hist   = '0;
      exp_rdy   = (64'd1 << 0) | (64'd1 << 12) | (64'd1 << 24);
      exp_rv    = (64'd1 << 11) | (64'd1 << 23) | (64'd1 << 35);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0045;
      for (int i = 0; i < 36; i++) begin
         if (i > 0) @(negedge clk);
         rdy_hist[i] = req_ready;
         rv_hist[i]  = resp_valid;
      end
      req_valid = 1'b0;
      check("b2b_ready_pattern", 256'(rdy_hist), 256'(exp_rdy));
      check("b2b_resp_pattern", 256'(rv_hist), 256'(exp_rv));
      check("b2b_rdata", resp_rdata, pat_a5);
      @(negedge clk);
      check("b2b_idle_after", 256'(state_dbg), 256'(IDLE));

      // Reset in the 5th BUSY cycle of a write: dropped, nothing committed.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h1000;
      req_wdata = pat_one;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_busy", 256'(state_dbg), 256'(BUSY));
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", 256'(req_ready), 256'(1));
      check("abort_state", 256'(state_dbg), 256'(IDLE));
      rv_seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rv_seen |= resp_valid;
      end
      check("abort_no_resp", 256'(rv_seen), 256'(0));
      run_req("rd_1000", 1'b0, 16'h1000, '0, 256'(0), 1'b0, '0);

      // Reset and req_valid together: no acceptance.
      reset     = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0040;
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 1'b0;
      check("rst_vs_valid_state", 256'(state_dbg), 256'(IDLE));
      @(negedge clk);
      check("rst_vs_valid_idle", 256'(state_dbg), 256'(IDLE));
      check("rst_vs_valid_ready", 256'(req_ready), 256'(1));

      // Wrap: 0x0200 is line 16, which aliases line 0 only in the 16-line instance.
      run_req("wrap_wr", 1'b1, 16'h0200, pat_c3, pat_c3, 1'b1, pat_c3);
      run_req("wrap_rd", 1'b0, 16'h0000, '0, 256'(0), 1'b1, pat_c3);
      run_req("rd_0200", 1'b0, 16'h0200, '0, pat_c3, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
